// File: rtl/regfile_dump.sv
// regfile_dump: debug readout engine for a register-file read port.
// On a start request it walks register indices 0..NREGS-1. For each index it
// spends one LOAD cycle driving the read address and capturing the read data,
// then presents an (index, value) beat on a valid/ready stream until the
// consumer accepts it. The register file is only read, never written.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - asynchronous active-low reset
//   start      - dump request, honoured only while idle
//   abort      - cancel an in-progress dump (no done pulse)
//   rf_ra      - register-file read address (registered index)
//   rf_rd      - register-file read data, combinational from rf_ra
//   out_valid  - beat available
//   out_ready  - consumer accepts the beat
//   out_addr   - register index of the beat
//   out_data   - snapshotted register value
//   out_last   - beat carries index NREGS-1
//   busy       - engine active (any state but idle)
//   done       - one-cycle pulse on normal completion
module regfile_dump #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  output logic [AW-1:0] rf_ra,
  input  logic [DW-1:0] rf_rd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_DONE
  } state_e;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] out_addr_q, out_addr_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
  logic          handshake;

  assign handshake = out_valid & out_ready;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
    end
  end

  // Next-state logic; abort outranks both start and the handshake
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (!abort && start) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = abort ? S_IDLE : S_SEND;
      end
      S_SEND: begin
        if (abort)          state_d = S_IDLE;
        else if (handshake) state_d = out_last_q ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Index walk and snapshot capture. The beat registers are only loaded at
  // the end of LOAD, so a register write landing on that same edge is not
  // seen and later writes cannot disturb a pending beat.
  always_comb begin
    idx_d      = idx_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    unique case (state_q)
      S_IDLE: begin
        idx_d = '0;
      end
      S_LOAD: begin
        if (abort) begin
          idx_d = '0;
        end else begin
          out_addr_d = idx_q;
          out_data_d = rf_rd;
          out_last_d = (idx_q == LAST_IDX);
        end
      end
      S_SEND: begin
        if (abort)                        idx_d = '0;
        else if (handshake && !out_last_q) idx_d = idx_q + 1'b1;
      end
      S_DONE: begin
        idx_d = '0;
      end
      default: idx_d = '0;
    endcase
  end

  // Outputs
  always_comb begin
    rf_ra     = idx_q;
    out_valid = (state_q == S_SEND);
    busy      = (state_q != S_IDLE);
    // An abort arriving in the completion cycle suppresses the pulse
    done      = (state_q == S_DONE) && !abort;
    out_addr  = out_addr_q;
    out_data  = out_data_q;
    out_last  = out_last_q;
  end

endmodule

// File: tb/tb_regfile_dump.sv
module tb_regfile_dump;

  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int          MAXC  = 200;
  localparam int          CW    = 4 + AW + DW + AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] rf_ra;
  logic [DW-1:0] rf_rd;
  logic          out_valid;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  // Behavioural register file with one synchronous write port
  logic [DW-1:0] tb_mem   [NREGS];
  logic [DW-1:0] init_mem [NREGS];
  logic          load_all = 1'b0;
  logic          wr_en    = 1'b0;
  logic [AW-1:0] wr_addr  = '0;
  logic [DW-1:0] wr_data  = '0;

  int checks   = 0;
  int failures = 0;

  // Per-cycle stimulus schedule, cycle 0 = start cycle
  bit            rdy_a   [MAXC];
  bit            start_a [MAXC];
  bit            abort_a [MAXC];
  int            nwr;
  int            wr_cyc  [4];
  int            wr_adr  [4];
  logic [DW-1:0] wr_dat  [4];

  // Expected / observed per-cycle words: {valid,busy,done,last,addr,data,ra}
  logic [CW-1:0] exp_w   [MAXC];
  logic [CW-1:0] obs_w   [MAXC];
  bit            e_valid [MAXC];
  bit            e_load  [MAXC];

  regfile_dump #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .rf_ra     (rf_ra),
    .rf_rd     (rf_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  assign rf_rd = tb_mem[rf_ra];

  always @(posedge clk) begin
    if (load_all) begin
      for (int i = 0; i < int'(NREGS); i++) tb_mem[i] <= init_mem[i];
    end else if (wr_en) begin
      tb_mem[wr_addr] <= wr_data;
    end
  end

  function automatic logic [CW-1:0] pack(input bit v, input bit b, input bit d, input bit l,
                                         input logic [AW-1:0] a, input logic [DW-1:0] dt,
                                         input logic [AW-1:0] ra);
    return {v, b, d, l, a, dt, ra};
  endfunction

  // Register content visible during cycle l: writes issued in earlier cycles apply
  function automatic logic [DW-1:0] mem_at(input int a, input int l);
    logic [DW-1:0] v;
    v = init_mem[a];
    for (int i = 0; i < nwr; i++)
      if (wr_adr[i] == a && wr_cyc[i] < l) v = wr_dat[i];
    return v;
  endfunction

  task automatic clear_sched();
    for (int i = 0; i < MAXC; i++) begin
      rdy_a[i]   = 1'b1;
      start_a[i] = 1'b0;
      abort_a[i] = 1'b0;
    end
    start_a[0] = 1'b1;
    nwr = 0;
  endtask

  task automatic preload(input bit rnd);
    for (int i = 0; i < int'(NREGS); i++)
      init_mem[i] = rnd ? DW'($urandom) : ((i == 0) ? '0 : (32'hA500_0000 + DW'(i)));
    load_all = 1'b1;
    @(posedge clk);
    #1 load_all = 1'b0;
  endtask

  // Transaction-level reference: one load cycle per beat, the beat then
  // waits for ready, the final acceptance is followed by one done cycle.
  task automatic build_model(input int n);
    int c;
    int k;
    bit stop;
    logic [DW-1:0] snap;
    for (int i = 0; i < n; i++) begin
      exp_w[i]   = '0;
      e_valid[i] = 1'b0;
      e_load[i]  = 1'b0;
    end
    c = 1;
    k = 0;
    stop = 1'b0;
    while (c < n) begin
      e_load[c] = 1'b1;
      exp_w[c]  = pack(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, AW'(k));
      if (abort_a[c]) break;
      snap = mem_at(k, c);
      c++;
      while (c < n) begin
        e_valid[c] = 1'b1;
        exp_w[c]   = pack(1'b1, 1'b1, 1'b0, (k == int'(NREGS) - 1), AW'(k), snap, '0);
        if (abort_a[c]) begin
          stop = 1'b1;
          break;
        end
        c++;
        if (rdy_a[c-1]) break;
      end
      if (stop || c >= n) break;
      if (k == int'(NREGS) - 1) begin
        exp_w[c] = pack(1'b0, 1'b1, !abort_a[c], 1'b0, '0, '0, '0);
        break;
      end
      k++;
    end
  endtask

  // Drives the schedule for n cycles and records masked observations
  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      start     = start_a[c];
      abort     = abort_a[c];
      out_ready = rdy_a[c];
      wr_en     = 1'b0;
      for (int i = 0; i < nwr; i++)
        if (wr_cyc[i] == c) begin
          wr_en   = 1'b1;
          wr_addr = AW'(wr_adr[i]);
          wr_data = wr_dat[i];
        end
      #1;
      obs_w[c] = {out_valid, busy, done,
                  (e_valid[c] ? {out_last, out_addr, out_data} : {(1+AW+DW){1'b0}}),
                  (e_load[c] ? rf_ra : {AW{1'b0}})};
      @(posedge clk);
      #1;
    end
    start = 1'b0; abort = 1'b0; out_ready = 1'b0; wr_en = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({rf_ra, out_valid, out_addr, out_data, out_last, busy, done} !== '0) begin
      failures++;
      $display("FAIL reset_async got ra=%h v=%b a=%h d=%h l=%b busy=%b done=%b required all 0",
               rf_ra, out_valid, out_addr, out_data, out_last, busy, done);
    end
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if ({rf_ra, out_valid, out_addr, out_data, out_last, busy, done} !== '0) begin
      failures++;
      $display("FAIL reset_held got ra=%h v=%b a=%h d=%h l=%b busy=%b done=%b required all 0",
               rf_ra, out_valid, out_addr, out_data, out_last, busy, done);
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int ndone;
    int nbeat;
    clear_sched();
    preload(1'b0);
    build_model(70);
    run(70);
    ndone = 0;
    nbeat = 0;
    for (int c = 0; c < 70; c++) begin
      checks++;
      if (obs_w[c] !== exp_w[c]) begin
        failures++;
        $display("FAIL basic cycle=%0d got=%h expected=%h", c, obs_w[c], exp_w[c]);
      end
      if (obs_w[c][CW-3]) ndone++;
      if (obs_w[c][CW-1] && rdy_a[c]) nbeat++;
    end
    checks++;
    if (obs_w[65][CW-3] !== 1'b1 || ndone != 1) begin
      failures++;
      $display("FAIL basic_done c65=%b count=%0d required 1 and 1", obs_w[65][CW-3], ndone);
    end
    checks++;
    if (nbeat != 32) begin
      failures++;
      $display("FAIL basic_beats got=%0d required=32", nbeat);
    end
  endtask

  task automatic test_backpressure();
    clear_sched();
    preload(1'b0);
    rdy_a[12] = 1'b0; rdy_a[13] = 1'b0; rdy_a[14] = 1'b0;
    build_model(74);
    run(74);
    for (int c = 0; c < 74; c++) begin
      checks++;
      if (obs_w[c] !== exp_w[c]) begin
        failures++;
        $display("FAIL backpressure cycle=%0d got=%h expected=%h", c, obs_w[c], exp_w[c]);
      end
    end
    for (int c = 12; c < 16; c++) begin
      checks++;
      if (obs_w[c][CW-1] !== 1'b1 || obs_w[c][2*AW+DW-1 -: AW] !== 5'd5 ||
          obs_w[c][AW+DW-1 -: DW] !== 32'hA500_0005) begin
        failures++;
        $display("FAIL bp_stall cycle=%0d got=%h required valid addr 5 data a5000005", c, obs_w[c]);
      end
    end
    checks++;
    if (obs_w[68][CW-3] !== 1'b1 || obs_w[65][CW-3] !== 1'b0) begin
      failures++;
      $display("FAIL bp_done c65=%b c68=%b required 0 and 1", obs_w[65][CW-3], obs_w[68][CW-3]);
    end
  endtask

  task automatic test_write_during_dump();
    logic [DW-1:0] w3;
    clear_sched();
    preload(1'b0);
    w3 = DW'($urandom);
    nwr = 2;
    wr_cyc[0] = 9;  wr_adr[0] = 3;  wr_dat[0] = w3;
    wr_cyc[1] = 21; wr_adr[1] = 10; wr_dat[1] = 32'hDEAD_BEEF;
    build_model(70);
    run(70);
    for (int c = 0; c < 70; c++) begin
      checks++;
      if (obs_w[c] !== exp_w[c]) begin
        failures++;
        $display("FAIL write_dump cycle=%0d got=%h expected=%h", c, obs_w[c], exp_w[c]);
      end
    end
    checks++;
    if (obs_w[22][AW+DW-1 -: DW] !== 32'hA500_000A) begin
      failures++;
      $display("FAIL write_snapshot beat10 got=%h required=a500000a", obs_w[22][AW+DW-1 -: DW]);
    end
  endtask

  task automatic test_abort();
    int ndone;
    clear_sched();
    preload(1'b1);
    abort_a[16] = 1'b1;
    build_model(24);
    run(24);
    ndone = 0;
    for (int c = 0; c < 24; c++) begin
      checks++;
      if (obs_w[c] !== exp_w[c]) begin
        failures++;
        $display("FAIL abort cycle=%0d got=%h expected=%h", c, obs_w[c], exp_w[c]);
      end
      if (obs_w[c][CW-3]) ndone++;
    end
    checks++;
    if (obs_w[17][CW-1 -: 3] !== 3'b000 || ndone != 0) begin
      failures++;
      $display("FAIL abort_idle c17 vbd=%b dones=%0d required 000 and 0", obs_w[17][CW-1 -: 3], ndone);
    end
    clear_sched();
    build_model(70);
    run(70);
    for (int c = 0; c < 70; c++) begin
      checks++;
      if (obs_w[c] !== exp_w[c]) begin
        failures++;
        $display("FAIL abort_restart cycle=%0d got=%h expected=%h", c, obs_w[c], exp_w[c]);
      end
    end
  endtask

  task automatic test_random_stall();
    clear_sched();
    preload(1'b1);
    for (int c = 1; c < MAXC; c++) rdy_a[c] = ($urandom_range(0, 3) != 0);
    nwr = 3;
    for (int i = 0; i < 3; i++) begin
      wr_cyc[i] = 10 + i * 40 + int'($urandom_range(0, 30));
      wr_adr[i] = int'($urandom_range(0, NREGS - 1));
      wr_dat[i] = DW'($urandom);
    end
    build_model(MAXC);
    run(MAXC);
    for (int c = 0; c < MAXC; c++) begin
      checks++;
      if (obs_w[c] !== exp_w[c]) begin
        failures++;
        $display("FAIL random_stall cycle=%0d got=%h expected=%h", c, obs_w[c], exp_w[c]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int ndone;
    clear_sched();
    preload(1'b0);
    start_a[10] = 1'b1;
    build_model(72);
    run(72);
    ndone = 0;
    for (int c = 0; c < 72; c++) begin
      checks++;
      if (obs_w[c] !== exp_w[c]) begin
        failures++;
        $display("FAIL start_busy cycle=%0d got=%h expected=%h", c, obs_w[c], exp_w[c]);
      end
      if (obs_w[c][CW-3]) ndone++;
    end
    checks++;
    if (ndone != 1) begin
      failures++;
      $display("FAIL start_busy_done count=%0d required=1", ndone);
    end
  endtask

  task automatic test_reset_mid_dump();
    clear_sched();
    preload(1'b0);
    build_model(26);
    run(26);
    for (int c = 0; c < 26; c++) begin
      checks++;
      if (obs_w[c] !== exp_w[c]) begin
        failures++;
        $display("FAIL reset_mid_pre cycle=%0d got=%h expected=%h", c, obs_w[c], exp_w[c]);
      end
    end
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 5'd12) begin
      failures++;
      $display("FAIL reset_mid_beat got v=%b a=%h required v=1 a=0c", out_valid, out_addr);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({rf_ra, out_valid, out_addr, out_data, out_last, busy, done} !== '0) begin
      failures++;
      $display("FAIL reset_mid_async got ra=%h v=%b a=%h d=%h l=%b busy=%b done=%b required all 0",
               rf_ra, out_valid, out_addr, out_data, out_last, busy, done);
    end
    @(posedge clk); @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if ({out_valid, busy, done} !== 3'b000) begin
        failures++;
        $display("FAIL reset_mid_quiet cycle=%0d got vbd=%b required 000", c, {out_valid, busy, done});
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_write_during_dump();
    test_abort();
    test_start_while_busy();
    test_random_stall();
    test_reset_mid_dump();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
